// File: rtl/icon_fetch_unit.sv
// icon_fetch_unit: queues foreign operand fetch requests, reads each operand
// from the producer TX buffer and writes it into the consumer RX buffer,
// strictly in acceptance order.
module icon_fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    input  logic                              req_valid,
    output logic                              req_ready,
    output logic [ADDR_WIDTH-1:0]             src_raddr,
    output logic                              src_rready,
    input  logic [DATA_WIDTH-1:0]             src_rdata,
    input  logic                              src_rvalid,
    output logic [ADDR_WIDTH-1:0]             dst_waddr,
    output logic [DATA_WIDTH-1:0]             dst_wdata,
    output logic                              dst_wvalid,
    input  logic                              dst_wready,
    output logic [$clog2(FIFO_DEPTH)+1:0]     pending
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned PEND_W = PTR_W + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [CNT_W-1:0]        wr_ptr;
    logic [CNT_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic [ADDR_WIDTH-1:0]   head;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;

    // Queue status; the extra pointer bit distinguishes full from empty
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[PTR_W-1:0]];

    // A full queue refuses a push even when a pop happens in the same cycle
    assign req_ready = ~full & ~reset;
    assign push      = req_valid & req_ready;

    // Queue storage; contents need no reset since the pointers gate validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= req_addr;
        end
    end

    // Queue pointers, wrapping modulo FIFO_DEPTH with a wrap bit
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CNT_W'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state and queue pop decision
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = READ;
                end
            end
            READ: begin
                if (src_rvalid) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (dst_wready) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        next_state = READ;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Address of the in-flight fetch, loaded from the queue head on pop
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
        end else if (pop) begin
            addr_q <= head;
        end
    end

    // Operand captured on a producer hit; read data is ignored outside READ
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if ((state == READ) && src_rvalid) begin
            data_q <= src_rdata;
        end
    end

    // Bus outputs decoded from state, forced idle while reset is asserted
    assign src_rready = (state == READ) & ~reset;
    assign src_raddr  = src_rready ? addr_q : '0;
    assign dst_wvalid = (state == WRITE) & ~reset;
    assign dst_waddr  = dst_wvalid ? addr_q : '0;
    assign dst_wdata  = dst_wvalid ? data_q : '0;
    assign pending    = reset ? '0 : (PEND_W'(count) + PEND_W'(state != IDLE));

endmodule

// File: tb/tb_icon_fetch_unit.sv
// Directed testbench for icon_fetch_unit (default parameters).
module tb_icon_fetch_unit;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned PW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] req_addr;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] src_raddr;
    logic          src_rready;
    logic [DW-1:0] src_rdata;
    logic          src_rvalid;
    logic [AW-1:0] dst_waddr;
    logic [DW-1:0] dst_wdata;
    logic          dst_wvalid;
    logic          dst_wready;
    logic [PW-1:0] pending;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc_cnt  = 0;

    logic [AW-1:0] log_addr [$];
    logic [DW-1:0] log_data [$];
    int            log_cyc  [$];

    icon_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_addr   (req_addr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .src_raddr  (src_raddr),
        .src_rready (src_rready),
        .src_rdata  (src_rdata),
        .src_rvalid (src_rvalid),
        .dst_waddr  (dst_waddr),
        .dst_wdata  (dst_wdata),
        .dst_wvalid (dst_wvalid),
        .dst_wready (dst_wready),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Record every completed consumer write (handshake seen mid-cycle)
    always @(negedge clk) begin
        if (dst_wvalid === 1'b1 && dst_wready === 1'b1) begin
            log_addr.push_back(dst_waddr);
            log_data.push_back(dst_wdata);
            log_cyc.push_back(cyc_cnt);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic log_clear();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic idle_inputs();
        req_valid  = 1'b0;
        req_addr   = '0;
        src_rvalid = 1'b0;
        src_rdata  = '0;
        dst_wready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        req_valid = 1'b1;
        req_addr  = 8'hEE;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({req_ready, src_rready, dst_wvalid, pending} !== {1'b0, 1'b0, 1'b0, 4'd0}) begin
            n_fails++;
            $display("FAIL reset_active: got rdy/rr/wv/pend=%b/%b/%b/%0d expected 0/0/0/0",
                     req_ready, src_rready, dst_wvalid, pending);
        end
        next_cycle();
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({req_ready, src_rready, dst_wvalid, pending} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            n_fails++;
            $display("FAIL reset_release: got rdy/rr/wv/pend=%b/%b/%b/%0d expected 1/0/0/0",
                     req_ready, src_rready, dst_wvalid, pending);
        end
    endtask

    task automatic test_single();
        log_clear();
        next_cycle();
        req_valid = 1'b1; req_addr = 8'h12;
        src_rvalid = 1'b1; src_rdata = 32'hDEADBEEF; dst_wready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL single_accept: got req_ready=%b expected 1", req_ready);
        end
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({src_rready, pending} !== {1'b0, 4'd1}) begin
            n_fails++;
            $display("FAIL single_queued: got rr=%b pend=%0d expected rr=0 pend=1", src_rready, pending);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({src_rready, src_raddr, dst_wvalid} !== {1'b1, 8'h12, 1'b0}) begin
            n_fails++;
            $display("FAIL single_read: got rr=%b raddr=%h wv=%b expected 1/12/0",
                     src_rready, src_raddr, dst_wvalid);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({dst_wvalid, dst_waddr, dst_wdata, src_rready, src_raddr} !==
            {1'b1, 8'h12, 32'hDEADBEEF, 1'b0, 8'h00}) begin
            n_fails++;
            $display("FAIL single_write: got wv=%b waddr=%h wdata=%h rr=%b raddr=%h expected 1/12/deadbeef/0/00",
                     dst_wvalid, dst_waddr, dst_wdata, src_rready, src_raddr);
        end
        next_cycle();
        src_rvalid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({pending, dst_wvalid, dst_waddr, dst_wdata} !== {4'd0, 1'b0, 8'h00, 32'h0}) begin
            n_fails++;
            $display("FAIL single_done: got pend=%0d wv=%b waddr=%h wdata=%h expected 0/0/00/0",
                     pending, dst_wvalid, dst_waddr, dst_wdata);
        end
        n_checks++;
        if (log_addr.size() !== 1) begin
            n_fails++;
            $display("FAIL single_count: got %0d writes expected 1", log_addr.size());
        end
    endtask

    task automatic test_producer_miss();
        int held = 0;
        logic [DW-1:0] d0;
        log_clear();
        next_cycle();
        req_valid = 1'b1; req_addr = 8'h34; src_rvalid = 1'b0; dst_wready = 1'b1;
        src_rdata = 32'h55555555;
        next_cycle();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            @(negedge clk);
            if (src_rready === 1'b1 && src_raddr === 8'h34 && dst_wvalid === 1'b0) held++;
        end
        next_cycle();
        src_rvalid = 1'b1; src_rdata = 32'hCAFEF00D;
        @(negedge clk);
        if (src_rready === 1'b1 && src_raddr === 8'h34 && dst_wvalid === 1'b0) held++;
        n_checks++;
        if (held !== 6) begin
            n_fails++;
            $display("FAIL miss_hold: got %0d read cycles at 34 expected 6", held);
        end
        next_cycle();
        src_rvalid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({dst_wvalid, dst_waddr, dst_wdata} !== {1'b1, 8'h34, 32'hCAFEF00D}) begin
            n_fails++;
            $display("FAIL miss_write: got wv=%b waddr=%h wdata=%h expected 1/34/cafef00d",
                     dst_wvalid, dst_waddr, dst_wdata);
        end
        for (int i = 0; i < 3; i++) next_cycle();
        @(negedge clk);
        d0 = (log_data.size() > 0) ? log_data[0] : 'x;
        n_checks++;
        if ({32'(log_addr.size()), d0, pending} !== {32'd1, 32'hCAFEF00D, 4'd0}) begin
            n_fails++;
            $display("FAIL miss_count: got writes=%0d data=%h pend=%0d expected 1/cafef00d/0",
                     log_addr.size(), d0, pending);
        end
    endtask

    task automatic test_backpressure();
        int stable = 0;
        logic [AW-1:0] a1;
        log_clear();
        next_cycle();
        req_valid = 1'b1; req_addr = 8'h56;
        src_rvalid = 1'b1; src_rdata = 32'h11112222; dst_wready = 1'b0;
        next_cycle();
        req_addr = 8'h57;
        next_cycle();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            src_rdata  = 32'h33334444;
            dst_wready = (i == 4);
            @(negedge clk);
            if (dst_wvalid === 1'b1 && dst_waddr === 8'h56 && dst_wdata === 32'h11112222 &&
                pending === 4'd2 && src_rready === 1'b0) stable++;
        end
        n_checks++;
        if (stable !== 5) begin
            n_fails++;
            $display("FAIL bp_stable: got %0d stable write cycles expected 5", stable);
        end
        next_cycle();
        dst_wready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({src_rready, src_raddr, dst_wvalid, pending} !== {1'b1, 8'h57, 1'b0, 4'd1}) begin
            n_fails++;
            $display("FAIL bp_next: got rr=%b raddr=%h wv=%b pend=%0d expected 1/57/0/1",
                     src_rready, src_raddr, dst_wvalid, pending);
        end
        next_cycle();
        dst_wready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({dst_wvalid, dst_waddr, dst_wdata} !== {1'b1, 8'h57, 32'h33334444}) begin
            n_fails++;
            $display("FAIL bp_second: got wv=%b waddr=%h wdata=%h expected 1/57/33334444",
                     dst_wvalid, dst_waddr, dst_wdata);
        end
        next_cycle();
        src_rvalid = 1'b0;
        @(negedge clk);
        a1 = (log_addr.size() > 1) ? log_addr[1] : 'x;
        n_checks++;
        if ({32'(log_addr.size()), a1, pending} !== {32'd2, 8'h57, 4'd0}) begin
            n_fails++;
            $display("FAIL bp_order: got writes=%0d second=%h pend=%0d expected 2/57/0",
                     log_addr.size(), a1, pending);
        end
    endtask

    task automatic test_full_queue();
        int accepted = 0;
        logic [AW-1:0] exp_a;
        logic [AW-1:0] got_a;
        log_clear();
        src_rvalid = 1'b0; dst_wready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            req_valid = 1'b1; req_addr = AW'(i);
            @(negedge clk);
            if (req_ready === 1'b1) accepted++;
        end
        n_checks++;
        if (accepted !== 5) begin
            n_fails++;
            $display("FAIL full_accept: got %0d accepted expected 5", accepted);
        end
        next_cycle();
        req_addr = 8'h06;
        @(negedge clk);
        n_checks++;
        if ({req_ready, pending} !== {1'b0, 4'd5}) begin
            n_fails++;
            $display("FAIL full_reject: got rdy=%b pend=%0d expected 0/5", req_ready, pending);
        end
        next_cycle();
        req_valid = 1'b0;
        src_rvalid = 1'b1; src_rdata = 32'hA5A5A5A5; dst_wready = 1'b1;
        for (int i = 0; i < 60 && log_addr.size() < 5; i++) next_cycle();
        for (int i = 0; i < 4; i++) next_cycle();
        @(negedge clk);
        n_checks++;
        if ({32'(log_addr.size()), pending} !== {32'd5, 4'd0}) begin
            n_fails++;
            $display("FAIL full_drain: got writes=%0d pend=%0d expected 5/0", log_addr.size(), pending);
        end
        for (int i = 0; i < 5; i++) begin
            exp_a = AW'(i + 1);
            got_a = (log_addr.size() > i) ? log_addr[i] : 'x;
            n_checks++;
            if (got_a !== exp_a) begin
                n_fails++;
                $display("FAIL full_order[%0d]: got %h expected %h", i, got_a, exp_a);
            end
        end
        src_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        log_clear();
        src_rvalid = 1'b1; src_rdata = 32'h77778888; dst_wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            req_valid = 1'b1; req_addr = AW'(8'h21 + i);
        end
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({dst_wvalid, dst_waddr, pending} !== {1'b1, 8'h21, 4'd3}) begin
            n_fails++;
            $display("FAIL rst_pre: got wv=%b waddr=%h pend=%0d expected 1/21/3",
                     dst_wvalid, dst_waddr, pending);
        end
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({req_ready, dst_wvalid, src_rready, pending} !== {1'b0, 1'b0, 1'b0, 4'd0}) begin
            n_fails++;
            $display("FAIL rst_during: got rdy/wv/rr/pend=%b/%b/%b/%0d expected 0/0/0/0",
                     req_ready, dst_wvalid, src_rready, pending);
        end
        next_cycle();
        reset = 1'b0; dst_wready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({req_ready, dst_wvalid, src_rready, pending} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            n_fails++;
            $display("FAIL rst_after: got rdy/wv/rr/pend=%b/%b/%b/%0d expected 1/0/0/0",
                     req_ready, dst_wvalid, src_rready, pending);
        end
        for (int i = 0; i < 10; i++) next_cycle();
        @(negedge clk);
        n_checks++;
        if ({32'(log_addr.size()), pending} !== {32'd0, 4'd0}) begin
            n_fails++;
            $display("FAIL rst_no_writes: got writes=%0d pend=%0d expected 0/0", log_addr.size(), pending);
        end
        src_rvalid = 1'b0; dst_wready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] got_a;
        int gap;
        log_clear();
        src_rvalid = 1'b1; src_rdata = 32'h0BADF00D; dst_wready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            req_valid = 1'b1; req_addr = AW'(8'h41 + i);
        end
        next_cycle();
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) next_cycle();
        @(negedge clk);
        n_checks++;
        if ({32'(log_addr.size()), pending} !== {32'd3, 4'd0}) begin
            n_fails++;
            $display("FAIL b2b_count: got writes=%0d pend=%0d expected 3/0", log_addr.size(), pending);
        end
        for (int i = 0; i < 3; i++) begin
            got_a = (log_addr.size() > i) ? log_addr[i] : 'x;
            n_checks++;
            if (got_a !== AW'(8'h41 + i)) begin
                n_fails++;
                $display("FAIL b2b_order[%0d]: got %h expected %h", i, got_a, AW'(8'h41 + i));
            end
        end
        for (int i = 1; i < 3; i++) begin
            gap = (log_cyc.size() > i) ? (log_cyc[i] - log_cyc[i-1]) : -1;
            n_checks++;
            if (gap !== 2) begin
                n_fails++;
                $display("FAIL b2b_gap[%0d]: got %0d cycles expected 2", i, gap);
            end
        end
        src_rvalid = 1'b0; dst_wready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_producer_miss();
        test_backpressure();
        test_full_queue();
        test_reset_mid_write();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/icon_fetch_unit.md
ICON_FETCH_UNIT -- requirements
Module: icon_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, width of the exec-unit operand address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of exec-unit operand data.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, request queue entries; power of two, >=2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_addr  input  ADDR_WIDTH  foreign operand address to fetch.
REQ-007 SHALL have port req_valid  input  1  fetch request present.
REQ-008 SHALL have port req_ready  output  1  request queue can accept.
REQ-009 SHALL have port src_raddr  output  ADDR_WIDTH  read address to producer TX buffer.
REQ-010 SHALL have port src_rready  output  1  read request strobe to producer.
REQ-011 SHALL have port src_rdata  input  DATA_WIDTH  producer read data.
REQ-012 SHALL have port src_rvalid  input  1  producer read hit, same cycle as src_rready.
REQ-013 SHALL have port dst_waddr  output  ADDR_WIDTH  write address to consumer RX buffer.
REQ-014 SHALL have port dst_wdata  output  DATA_WIDTH  write data to consumer RX buffer.
REQ-015 SHALL have port dst_wvalid  output  1  write valid to consumer.
REQ-016 SHALL have port dst_wready  input  1  consumer RX buffer can accept.
REQ-017 SHALL have port pending  output  $clog2(FIFO_DEPTH)+2  queued plus in-flight requests.

Function
REQ-018 Request queue: FIFO of FIFO_DEPTH addresses; push when req_valid & req_ready; req_ready = ~full & ~reset; no bypass of an empty queue.
REQ-019 Pushed entry visible to FSM the cycle after the push edge; full queue rejects push even if a pop occurs same cycle.
REQ-020 FSM states IDLE, READ, WRITE; reset state IDLE.
REQ-021 IDLE: queue non-empty -> pop head into addr register, go READ; else stay.
REQ-022 READ: src_rready=1, src_raddr=addr register; src_rvalid=1 -> capture src_rdata, go WRITE; src_rvalid=0 -> stay, retry next cycle indefinitely.
REQ-023 src_rvalid and src_rdata SHALL be ignored in any state other than READ.
REQ-024 WRITE: dst_wvalid=1, dst_waddr=addr register, dst_wdata=captured data, all held stable until dst_wready=1.
REQ-025 WRITE with dst_wready=1: queue non-empty -> pop head, go READ (back-to-back); empty -> go IDLE.
REQ-026 Best-case latency: push at edge N, READ asserted cycle N+2, dst_wvalid cycle N+3; sustained throughput one fetch per 2 cycles.
REQ-027 Outside READ: src_rready=0, src_raddr=0; outside WRITE: dst_wvalid=0, dst_waddr=0, dst_wdata=0.
REQ-028 pending = queue occupancy + (state != IDLE); simultaneous push and pop leave occupancy unchanged.
REQ-029 Requests complete strictly in acceptance order; duplicate addresses are fetched separately, no merging.
REQ-030 Pointer wrap: read/write pointers wrap modulo FIFO_DEPTH; full/empty by extra wrap bit.

Reset
REQ-031 reset=1 at a clock edge SHALL empty the queue, set state IDLE, clear addr/data registers, discarding any in-flight fetch.
REQ-032 While reset=1 and the cycle after: req_ready=0 during reset, src_rready=0, dst_wvalid=0, pending=0; req_ready=1 first cycle after reset deasserts.

Verification
REQ-033 Single fetch: push 0x12, src_rvalid=1 data 0xDEADBEEF, dst_wready=1 -> READ at N+2 with src_raddr=0x12, dst_wvalid at N+3 with 0x12/0xDEADBEEF, pending returns 0.
REQ-034 Producer miss: src_rvalid=0 for 5 READ cycles then 1 -> src_rready held 6 cycles, src_raddr stable, exactly one dst write.
REQ-035 Consumer backpressure: dst_wready=0 for 4 cycles -> dst_wvalid/addr/data stable 5 cycles, no second pop.
REQ-036 Full queue: push 5 requests with FIFO_DEPTH=4, producer stalled -> req_ready=0 after 4th accepted into queue plus 1 in flight, 6th rejected, order preserved 0x01..0x05.
REQ-037 Reset mid-WRITE: assert reset while dst_wvalid=1 with 2 queued -> next cycle dst_wvalid=0, pending=0, no further writes after release.
REQ-038 Back-to-back: 3 requests, both sides always ready -> dst writes every 2 cycles, addresses in push order.
